// File: rtl/clint_pkg.sv
// Shared definitions for the clint block: register offsets, bus FSM states
// and the mtimecmp reset value.
package clint_pkg;

    localparam logic [4:0] CLINT_MSIP_OFF     = 5'h00;
    localparam logic [4:0] CLINT_SSIP_OFF     = 5'h04;
    localparam logic [4:0] CLINT_MTIMECMP_OFF = 5'h08;
    localparam logic [4:0] CLINT_MTIME_OFF    = 5'h10;

    // All ones keeps the timer interrupt quiet until software programs it.
    localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } clint_state_e;

endpackage

// File: rtl/mtime_counter.sv
// Free-running 64-bit mtime with a CLOCK_DIV prescaler and a byte-granular
// load port. A load wins over an increment on the same edge.
module mtime_counter #(
    parameter int CLOCK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] load_data,
    input  logic [7:0]  load_be,
    output logic [63:0] mtime
);

    localparam int PW = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLOCK_DIV - 1);

    logic [PW-1:0] pre;
    logic          tick;
    logic [63:0]   loaded;

    assign tick = (pre == PRE_MAX);

    always_comb begin
        loaded = mtime;
        for (int b = 0; b < 8; b++) begin
            if (load_be[b]) loaded[b*8 +: 8] = load_data[b*8 +: 8];
        end
    end

    // The prescaler keeps its phase across loads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre   <= '0;
            mtime <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (|load_be)  mtime <= loaded;
            else if (tick) mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip/ssip, mtime and mtimecmp behind a 3-state bus FSM.
// Build option: define CLINT_SSIP_EN to implement the ssip register at 0x04.
module clint
    import clint_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int CLOCK_DIV = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [DATA_SIZE/8-1:0] byte_en,
    input  logic [4:0]             addr,
    input  logic [DATA_SIZE-1:0]   wr_data,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   busy,
    output logic                   msip,
    output logic                   ssip,
    output logic [63:0]            mtime,
    output logic [63:0]            mtimecmp
);

    localparam int NB = DATA_SIZE / 8;
    localparam int AL = $clog2(NB);
    localparam logic [4:0] HI_STEP = (DATA_SIZE == 32) ? 5'h04 : 5'h00;

    clint_state_e         state_q, state_d;
    logic [4:0]           addr_q;
    logic [DATA_SIZE-1:0] wdata_q;
    logic [NB-1:0]        be_q;
    logic                 is_wr_q;
    logic                 req, wr_go;
    logic                 aligned, hit_msip, hit_ssip, hit_cmp, hit_time;
    logic [63:0]          wd64, rsel;
    logic [7:0]           be64;
    logic [DATA_SIZE-1:0] rd_next;

    assign req = rd_en | wr_en;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign busy  = (state_q == ST_IDLE && req) || (state_q == ST_ACCESS);
    assign wr_go = (state_q == ST_ACCESS) && is_wr_q;

    // A request with both enables set is treated as a write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            is_wr_q <= 1'b0;
        end else if (state_q == ST_IDLE && req) begin
            addr_q  <= addr;
            wdata_q <= wr_data;
            be_q    <= byte_en;
            is_wr_q <= wr_en;
        end
    end

    assign aligned  = (addr_q[AL-1:0] == '0);
    assign hit_msip = aligned && (addr_q == CLINT_MSIP_OFF);
    assign hit_cmp  = aligned && (addr_q == CLINT_MTIMECMP_OFF || addr_q == CLINT_MTIMECMP_OFF + HI_STEP);
    assign hit_time = aligned && (addr_q == CLINT_MTIME_OFF || addr_q == CLINT_MTIME_OFF + HI_STEP);
`ifdef CLINT_SSIP_EN
    assign hit_ssip = aligned && (addr_q == CLINT_SSIP_OFF);
`else
    assign hit_ssip = 1'b0;
`endif

    // Map the bus word onto a 64-bit register view; on a 32-bit bus addr[2]
    // picks the upper half.
    generate
        if (DATA_SIZE == 64) begin : g_bus64
            assign wd64    = wdata_q;
            assign be64    = be_q;
            assign rd_next = rsel;
        end else begin : g_bus32
            assign wd64    = {wdata_q, wdata_q};
            assign be64    = addr_q[2] ? {be_q, 4'b0000} : {4'b0000, be_q};
            assign rd_next = addr_q[2] ? rsel[63:32] : rsel[31:0];
        end
    endgenerate

    always_comb begin
        rsel = '0;
        if (hit_msip) rsel = {63'd0, msip};
        if (hit_ssip) rsel = {2{31'd0, ssip}};
        if (hit_cmp)  rsel = mtimecmp;
        if (hit_time) rsel = mtime;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            msip     <= 1'b0;
            mtimecmp <= CLINT_MTIMECMP_RST;
        end else if (wr_go) begin
            if (hit_msip && be64[0]) msip <= wd64[0];
            if (hit_cmp) begin
                for (int b = 0; b < 8; b++) begin
                    if (be64[b]) mtimecmp[b*8 +: 8] <= wd64[b*8 +: 8];
                end
            end
        end
    end

`ifdef CLINT_SSIP_EN
    // ssip lives at 0x04, i.e. the upper lane of the 64-bit view.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                            ssip <= 1'b0;
        else if (wr_go && hit_ssip && be64[4]) ssip <= wd64[32];
    end
`else
    assign ssip = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                  rd_data <= '0;
        else if (state_q == ST_ACCESS && !is_wr_q) rd_data <= rd_next;
    end

    mtime_counter #(.CLOCK_DIV(CLOCK_DIV)) u_mtime (
        .clock     (clock),
        .reset     (reset),
        .load_data (wd64),
        .load_be   ((wr_go && hit_time) ? be64 : 8'h00),
        .mtime     (mtime)
    );

endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (CLOCK_DIV 1 and 3) share one 32-bit bus,
// checked by vector table, hand sequences and random accesses vs a model.
module tb_clint;

`ifdef CLINT_SSIP_EN
    localparam bit SSIP_EN = 1'b1;
`else
    localparam bit SSIP_EN = 1'b0;
`endif

    logic        clock = 1'b0, reset = 1'b1, rd_en = 1'b0, wr_en = 1'b0;
    logic [3:0]  byte_en = '0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data1, rd_data3;
    logic        busy1, busy3, msip1, msip3, ssip1, ssip3;
    logic [63:0] mtime1, mtime3, cmp1, cmp3;

    clint #(.DATA_SIZE(32), .CLOCK_DIV(1)) dut1 (
        .clock(clock), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .byte_en(byte_en),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data1), .busy(busy1), .msip(msip1),
        .ssip(ssip1), .mtime(mtime1), .mtimecmp(cmp1));

    clint #(.DATA_SIZE(32), .CLOCK_DIV(3)) dut3 (
        .clock(clock), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .byte_en(byte_en),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data3), .busy(busy3), .msip(msip3),
        .ssip(ssip3), .mtime(mtime3), .mtimecmp(cmp3));

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Model: mtime(n) = value loaded at edge lload + number of multiples of
    // the divider in (lload, n].
    int          div [2] = '{1, 3};
    logic [63:0] mt_val [2];
    int          lload [2];
    logic        m_msip, m_ssip;
    logic [63:0] m_cmp;

    function automatic logic [63:0] mt_at(int i, int n);
        return mt_val[i] + 64'(n / div[i]) - 64'(lload[i] / div[i]);
    endfunction

    function automatic logic [63:0] merge(logic [63:0] old, logic [31:0] d, logic [3:0] be, bit hi);
        logic [63:0] v = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) v[(hi ? 32 : 0) + b*8 +: 8] = d[b*8 +: 8];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mt_val[i] = '0;
            lload[i]  = 0;
        end
        m_msip = 1'b0;
        m_ssip = 1'b0;
        m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    function automatic logic [31:0] read_model(int i, logic [4:0] a, int n);
        logic [63:0] t = mt_at(i, n);
        case (a)
            5'h00:   return {31'd0, m_msip};
            5'h04:   return SSIP_EN ? {31'd0, m_ssip} : 32'd0;
            5'h08:   return m_cmp[31:0];
            5'h0C:   return m_cmp[63:32];
            5'h10:   return t[31:0];
            5'h14:   return t[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus access; returns after the cycle in which busy falls.
    task automatic access(input bit wr, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] r1, output logic [31:0] r3);
        logic [63:0] v;
        @(negedge clock);
        wr_en = wr; rd_en = !wr; addr = a; wr_data = d; byte_en = be;
        #1 chk("busy_req", busy1, 1'b1);
        @(negedge clock);
        rd_en = 1'b0; wr_en = 1'b0;
        #1 chk("busy_access", busy3, 1'b1);
        @(negedge clock);
        #1 chk("busy_done", {busy1, busy3}, 2'b00);
        r1 = rd_data1;
        r3 = rd_data3;
        if (!wr) begin
            chk($sformatf("rd_data_div1 @%h", a), r1, read_model(0, a, cyc - 1));
            chk($sformatf("rd_data_div3 @%h", a), r3, read_model(1, a, cyc - 1));
        end else begin
            case (a)
                5'h00: if (be[0]) m_msip = d[0];
                5'h04: if (SSIP_EN && be[0]) m_ssip = d[0];
                5'h08: m_cmp = merge(m_cmp, d, be, 1'b0);
                5'h0C: m_cmp = merge(m_cmp, d, be, 1'b1);
                5'h10, 5'h14:
                    for (int i = 0; i < 2; i++) begin
                        v = mt_at(i, cyc - 1);
                        mt_val[i] = merge(v, d, be, a[2]);
                        lload[i]  = cyc;
                    end
                default: ;
            endcase
        end
    endtask

    always @(negedge clock) begin
        #2;
        if (mon_en && !reset) begin
            chk("mtime_div1", mtime1, mt_at(0, cyc));
            chk("mtime_div3", mtime3, mt_at(1, cyc));
            chk("mtimecmp", cmp1, m_cmp);
            chk("mtimecmp_div3", cmp3, m_cmp);
            chk("msip", {msip1, msip3}, {2{m_msip}});
            chk("ssip", {ssip1, ssip3}, {2{m_ssip}});
        end
    end

    typedef struct {
        bit          wr;
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r1, r3;
        int n;

        tbl[0]  = '{1'b1, 5'h00, 32'h0000_0001, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, 5'h00, 32'h0,         4'hF, 32'h0000_0001};
        tbl[2]  = '{1'b1, 5'h08, 32'h0000_0100, 4'hF, 32'h0};
        tbl[3]  = '{1'b1, 5'h0C, 32'h0000_0000, 4'hF, 32'h0};
        tbl[4]  = '{1'b0, 5'h08, 32'h0,         4'hF, 32'h0000_0100};
        tbl[5]  = '{1'b0, 5'h0C, 32'h0,         4'hF, 32'h0000_0000};
        tbl[6]  = '{1'b1, 5'h08, 32'hAABB_CCDD, 4'b0010, 32'h0};
        tbl[7]  = '{1'b0, 5'h08, 32'h0,         4'hF, 32'h0000_CC00};
        tbl[8]  = '{1'b1, 5'h04, 32'h0000_0001, 4'hF, 32'h0};
        tbl[9]  = '{1'b0, 5'h04, 32'h0,         4'hF, SSIP_EN ? 32'h1 : 32'h0};
        tbl[10] = '{1'b0, 5'h01, 32'h0,         4'hF, 32'h0};
        tbl[11] = '{1'b1, 5'h01, 32'h0,         4'hF, 32'h0};
        tbl[12] = '{1'b0, 5'h00, 32'h0,         4'hF, 32'h0000_0001};
        tbl[13] = '{1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[14] = '{1'b0, 5'h18, 32'h0,         4'hF, 32'h0};
        tbl[15] = '{1'b1, 5'h00, 32'h0,         4'hE, 32'h0};
        tbl[16] = '{1'b0, 5'h00, 32'h0,         4'hF, 32'h0000_0001};

        // Reset state, then 10 idle cycles.
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_busy", {busy1, busy3}, 2'b00);
        chk("rst_rd_data", rd_data1, 32'h0);
        chk("rst_mtime", mtime1, 64'h0);
        chk("rst_mtimecmp", cmp1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_msip_ssip", {msip1, ssip1}, 2'b00);
        repeat (10) @(negedge clock);
        #1;
        chk("idle10_mtime_div1", mtime1, 64'd10);
        chk("idle10_mtime_div3", mtime3, 64'd3);
        chk("idle10_busy", busy1, 1'b0);
        mon_en = 1'b1;

        for (int i = 0; i < NV; i++) begin
            access(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].be, r1, r3);
            if (!tbl[i].wr) begin
                chk($sformatf("vec%0d_rd_div1", i), r1, tbl[i].exp);
                chk($sformatf("vec%0d_rd_div3", i), r3, tbl[i].exp);
            end
        end
        chk("vec_mtimecmp", cmp1, 64'h0000_0000_0000_CC00);
        chk("vec_ssip", ssip1, SSIP_EN);

        // Load near the top of the range and watch the wrap.
        access(1'b1, 5'h10, 32'h0, 4'hF, r1, r3);
        access(1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF, r1, r3);
        access(1'b1, 5'h10, 32'hFFFF_FFFE, 4'hF, r1, r3);
        chk("load_prio_div1", mtime1, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("load_div3", mtime3, 64'hFFFF_FFFF_FFFF_FFFE);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (mtime3 == 64'hFFFF_FFFF_FFFF_FFFE && n < 4);
        chk("wrap_first_gap_le3", n <= 3, 1'b1);
        chk("wrap_ffff", mtime3, 64'hFFFF_FFFF_FFFF_FFFF);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (mtime3 == 64'hFFFF_FFFF_FFFF_FFFF && n < 5);
        chk("wrap_gap", n, 3);
        chk("wrap_zero", mtime3, 64'h0);

        // Randomised accesses against the model.
        repeat (150) begin
            int sel;
            logic [4:0] a;
            sel = $urandom_range(0, 9);
            case (sel)
                0: a = 5'h00;
                1: a = 5'h04;
                2: a = 5'h08;
                3: a = 5'h0C;
                4: a = 5'h10;
                5: a = 5'h14;
                6: a = 5'h18;
                default: a = 5'($urandom);
            endcase
            access(1'($urandom), a, $urandom, 4'($urandom), r1, r3);
        end

        // Reset in the middle of an msip write aborts it.
        access(1'b1, 5'h00, 32'h0, 4'hF, r1, r3);
        @(negedge clock);
        wr_en = 1'b1; addr = 5'h00; wr_data = 32'h1; byte_en = 4'hF;
        @(negedge clock);
        wr_en = 1'b0;
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {busy1, busy3}, 2'b00);
        chk("rst_mid_msip", {msip1, msip3}, 2'b00);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        #1;
        chk("rst_mid_mtimecmp", cmp3, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_mid_rd_data", rd_data3, 32'h0);
        access(1'b0, 5'h00, 32'h0, 4'hF, r1, r3);
        chk("rst_mid_rd_msip", r1, 32'h0);

        @(negedge clock);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
